even_parity_frame_checker: RTL and testbench

EVEN_PARITY_FRAME_CHECKER -- requirements
Module: even_parity_frame_checker

---
 rtl/even_parity_frame_checker.sv | 133 +++++++++++++
 tb/tb_even_parity_frame_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/even_parity_frame_checker.sv
// even_parity_frame_checker: receives a serial frame (start, A, B, C, even
// parity P, stop), checks parity and framing, and presents the 3-bit word
// with error flags behind a VALID/ACK hold register. Overruns are sticky
// and errored frames are tallied in a saturating 8-bit counter.
module even_parity_frame_checker #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       SIN,
    input  logic       ACK,
    output logic [2:0] D,
    output logic       VALID,
    output logic       PERR,
    output logic       FERR,
    output logic       OVR,
    output logic       BUSY,
    output logic [7:0] ERRCNT
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int unsigned CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    bitn;
    logic [2:0]    sh;
    logic          par_err;
    logic          at_sample;
    logic          stop_done;
    logic          frame_err;

    assign at_sample = (cnt == LAST);
    assign stop_done = (state == S_STOP) && at_sample;
    assign frame_err = par_err | ~SIN;

    // Busy whenever a frame is being received.
    always_comb begin
        BUSY = (state != S_IDLE);
    end

    // Receive FSM: start qualification, mid-bit sampling of data/parity/stop.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bitn    <= '0;
            sh      <= '0;
            par_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!SIN) state <= S_START;
                end
                S_START: begin
                    if (cnt == HALF) begin
                        cnt  <= '0;
                        bitn <= '0;
                        state <= SIN ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (at_sample) begin
                        cnt <= '0;
                        sh  <= {SIN, sh[2:1]};
                        if (bitn == 2'd2) state <= S_PARITY;
                        else              bitn  <= bitn + 2'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (at_sample) begin
                        cnt     <= '0;
                        par_err <= ^{sh, SIN};
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (at_sample) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Hold register, overrun flag and saturating error tally.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            D      <= '0;
            VALID  <= 1'b0;
            PERR   <= 1'b0;
            FERR   <= 1'b0;
            OVR    <= 1'b0;
            ERRCNT <= '0;
        end else begin
            if (stop_done) begin
                if (!VALID || ACK) begin
                    D     <= sh;
                    PERR  <= par_err;
                    FERR  <= ~SIN;
                    VALID <= 1'b1;
                end else begin
                    OVR <= 1'b1;
                end
                if (frame_err && (ERRCNT != 8'hFF)) ERRCNT <= ERRCNT + 8'd1;
            end else if (VALID && ACK) begin
                VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_even_parity_frame_checker.sv
// Self-checking bench for even_parity_frame_checker: directed frames for the
// key behaviours plus randomized frames against a frame-level reference model.
module tb_even_parity_frame_checker;

    localparam int unsigned BC = 4;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       SIN;
    logic       ACK;
    logic [2:0] D;
    logic       VALID;
    logic       PERR;
    logic       FERR;
    logic       OVR;
    logic       BUSY;
    logic [7:0] ERRCNT;

    int total = 0;
    int bad   = 0;

    // Frame-level reference model of the hold register and status.
    logic       m_valid;
    logic [2:0] m_d;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovr;
    int         m_errcnt;

    always #5 CLK = ~CLK;

    even_parity_frame_checker #(.BIT_CYCLES(BC)) dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .SIN   (SIN),
        .ACK   (ACK),
        .D     (D),
        .VALID (VALID),
        .PERR  (PERR),
        .FERR  (FERR),
        .OVR   (OVR),
        .BUSY  (BUSY),
        .ERRCNT(ERRCNT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_d      = 3'b000;
        m_perr   = 1'b0;
        m_ferr   = 1'b0;
        m_ovr    = 1'b0;
        m_errcnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  {31'd0, VALID}, {31'd0, m_valid});
        chk({tag, ".d"},      {29'd0, D},     {29'd0, m_d});
        chk({tag, ".perr"},   {31'd0, PERR},  {31'd0, m_perr});
        chk({tag, ".ferr"},   {31'd0, FERR},  {31'd0, m_ferr});
        chk({tag, ".ovr"},    {31'd0, OVR},   {31'd0, m_ovr});
        chk({tag, ".errcnt"}, {24'd0, ERRCNT}, m_errcnt);
        chk({tag, ".busy"},   {31'd0, BUSY},  32'd0);
    endtask

    task automatic send_bit(input logic b);
        SIN = b;
        repeat (BC) cyc();
    endtask

    // Drives one frame; ack_stop holds ACK high during the stop-sample cycle.
    task automatic send_frame(input logic a, input logic b, input logic c,
                              input logic p, input logic stp, input logic ack_stop);
        logic err;
        send_bit(1'b0);
        send_bit(a);
        send_bit(b);
        send_bit(c);
        send_bit(p);
        SIN = stp;
        repeat (BC - 1) cyc();
        ACK = ack_stop;
        cyc();
        ACK = 1'b0;
        SIN = 1'b1;
        err = ((a + b + c + p) % 2 == 1) || (stp == 1'b0);
        if (!m_valid || ack_stop) begin
            m_valid = 1'b1;
            m_d     = {c, b, a};
            m_perr  = ((a + b + c + p) % 2 == 1);
            m_ferr  = !stp;
        end else begin
            m_ovr = 1'b1;
        end
        if (err && m_errcnt < 255) m_errcnt++;
    endtask

    task automatic do_ack();
        ACK = 1'b1;
        cyc();
        ACK = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        cyc();
        RSTN = 1'b1;
        cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] r;
        RSTN = 1'b0;
        SIN  = 1'b1;
        ACK  = 1'b0;
        model_reset();
        cyc();
        cyc();
        check_all("por");
        RSTN = 1'b1;
        cyc();

        // Clean frame A=1 B=0 C=1 P=0
        send_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_all("clean");
        chk("clean.d101", {29'd0, D}, 32'd5);
        ACK = 1'b1;
        cyc();
        ACK = 1'b0;
        m_valid = 1'b0;
        chk("clean.ackclr", {31'd0, VALID}, 32'd0);

        // ACK with nothing held is ignored
        do_ack();
        check_all("idleack");

        // Parity error A=1 B=1 C=0 P=1
        send_frame(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all("perr");
        chk("perr.flag", {31'd0, PERR}, 32'd1);
        chk("perr.cnt", {24'd0, ERRCNT}, 32'd1);
        do_ack();

        // One-cycle low glitch on idle line
        SIN = 1'b0;
        cyc();
        SIN = 1'b1;
        cyc();
        chk("glitch.busy", {31'd0, BUSY}, 32'd1);
        repeat (2 * BC) cyc();
        check_all("glitch");

        // Framing error: stop bit low
        send_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("ferr");
        chk("ferr.flag", {31'd0, FERR}, 32'd1);
        do_ack();

        // Overrun: two frames back to back, no ACK
        send_frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_all("ovr");
        chk("ovr.d", {29'd0, D}, 32'd2);
        chk("ovr.flag", {31'd0, OVR}, 32'd1);
        do_ack();

        // ACK coincident with second stop: new word loaded, OVR unchanged
        send_frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check_all("ackstop1");
        chk("ackstop1.d", {29'd0, D}, 32'd4);
        do_reset();
        send_frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check_all("ackstop0");
        chk("ackstop0.ovr", {31'd0, OVR}, 32'd0);
        do_ack();

        // Randomized frames, gaps and acknowledgements
        for (int i = 0; i < 40; i++) begin
            r = 5'($urandom);
            send_frame(r[0], r[1], r[2], r[3], ($urandom_range(0, 5) != 0), r[4]);
            check_all("rand");
            if ($urandom_range(0, 1) == 1) do_ack();
            repeat ($urandom_range(0, 2)) cyc();
        end

        // Saturation of the error tally
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        check_all("sat");
        chk("sat.255", {24'd0, ERRCNT}, 32'd255);
        send_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all("sat.hold");
        chk("sat.hold255", {24'd0, ERRCNT}, 32'd255);

        // Reset mid-DATA: immediate clear and no VALID from the aborted frame
        send_bit(1'b0);
        send_bit(1'b1);
        SIN = 1'b0;
        cyc();
        chk("midrst.busy", {31'd0, BUSY}, 32'd1);
        RSTN = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        SIN = 1'b1;
        cyc();
        cyc();
        RSTN = 1'b1;
        repeat (8 * BC) cyc();
        check_all("midrst.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
